// File: rtl/shift_rot_pipe.sv
// Pipelined barrel shifter/rotator: log2(WIDTH) stages, one register bank per stage,
// valid/ready flow control with a combinational ready chain.
module shift_rot_pipe #(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned SHAMT_W = $clog2(WIDTH),
    parameter int unsigned TAG_W   = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SHAMT_W-1:0] in_shamt,
    input  logic [1:0]         in_op,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [TAG_W-1:0]   out_tag
);

    // op encoding: 00 ROL, 01 SLL, 10 ROR, 11 SRL
    function automatic logic [WIDTH-1:0] stage_shift(input logic [WIDTH-1:0] d,
                                                     input logic [1:0]       op,
                                                     input int unsigned      s);
        logic [WIDTH-1:0] r;
        case (op)
            2'b00:   r = (d << s) | (d >> (WIDTH - s));
            2'b01:   r = d << s;
            2'b10:   r = (d >> s) | (d << (WIDTH - s));
            default: r = d >> s;
        endcase
        return r;
    endfunction

    logic [SHAMT_W-1:0] valid_vec;
    logic [SHAMT_W-1:0] adv;
    logic [WIDTH-1:0]   data_a [SHAMT_W];
    logic [TAG_W-1:0]   tag_a  [SHAMT_W];
    logic [SHAMT_W-1:0] rem_a  [SHAMT_W-1];
    logic [1:0]         op_a   [SHAMT_W-1];

    for (genvar k = 0; k < SHAMT_W; k++) begin : g_stage
        logic               src_valid;
        logic [WIDTH-1:0]   src_data;
        logic [SHAMT_W-1:0] src_shamt;
        logic [1:0]         src_op;
        logic [TAG_W-1:0]   src_tag;
        logic [WIDTH-1:0]   src_res;
        logic               valid_q;
        logic [WIDTH-1:0]   data_q;
        logic [TAG_W-1:0]   tag_q;

        if (k == 0) begin : g_src_in
            assign src_valid = in_valid;
            assign src_data  = in_data;
            assign src_shamt = in_shamt;
            assign src_op    = in_op;
            assign src_tag   = in_tag;
        end else begin : g_src_prev
            assign src_valid = valid_vec[k-1];
            assign src_data  = data_a[k-1];
            assign src_shamt = rem_a[k-1];
            assign src_op    = op_a[k-1];
            assign src_tag   = tag_a[k-1];
        end

        // Shift amount is consumed LSB-first; each stage hands on the remaining bits.
        assign src_res = src_shamt[0] ? stage_shift(src_data, src_op, 1 << k) : src_data;

        // Closed form of the ready chain: advance unless every stage from here on is full
        // and the consumer is stalling.
        assign adv[k] = out_ready || !(&valid_vec[SHAMT_W-1:k]);

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                valid_q <= 1'b0;
                data_q  <= '0;
                tag_q   <= '0;
            end else if (flush) begin
                valid_q <= 1'b0;
            end else if (adv[k]) begin
                valid_q <= src_valid;
                if (src_valid) begin
                    data_q <= src_res;
                    tag_q  <= src_tag;
                end
            end
        end

        assign valid_vec[k] = valid_q;
        assign data_a[k]    = data_q;
        assign tag_a[k]     = tag_q;

        if (k < SHAMT_W - 1) begin : g_carry
            logic [SHAMT_W-1:0] rem_q;
            logic [1:0]         op_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rem_q <= '0;
                    op_q  <= '0;
                end else if (!flush && adv[k] && src_valid) begin
                    rem_q <= src_shamt >> 1;
                    op_q  <= src_op;
                end
            end

            assign rem_a[k] = rem_q;
            assign op_a[k]  = op_q;
        end
    end

    assign in_ready  = adv[0] && !flush;
    assign out_valid = valid_vec[SHAMT_W-1];
    assign out_data  = data_a[SHAMT_W-1];
    assign out_tag   = tag_a[SHAMT_W-1];

endmodule

// File: tb/tb_shift_rot_pipe.sv
// Directed bench for shift_rot_pipe (WIDTH=16, 4 stages): latency, modes, back-pressure,
// flush, asynchronous reset and a scoreboarded random stream.
module tb_shift_rot_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic [3:0]  in_shamt;
    logic [1:0]  in_op;
    logic [3:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [3:0]  out_tag;

    int checks   = 0;
    int failures = 0;

    shift_rot_pipe #(.WIDTH(16), .TAG_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_shamt  (in_shamt),
        .in_op     (in_op),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag)
    );

    always #5 clk = ~clk;

    // Directed vectors: {op, shamt, data, expected}
    logic [1:0]  bb_op   [8] = '{2'b10, 2'b00, 2'b11, 2'b01, 2'b10, 2'b00, 2'b11, 2'b10};
    logic [3:0]  bb_sh   [8] = '{4'd1, 4'd15, 4'd15, 4'd0, 4'd0, 4'd4, 4'd7, 4'd8};
    logic [15:0] bb_din  [8] = '{16'h8001, 16'h8001, 16'h8000, 16'h1234,
                                 16'hABCD, 16'h1234, 16'hF000, 16'h0001};
    logic [15:0] bb_exp  [8] = '{16'hC000, 16'hC000, 16'h0001, 16'h1234,
                                 16'hABCD, 16'h2341, 16'h01E0, 16'h0100};

    logic [1:0]  bp_op   [6] = '{2'b01, 2'b11, 2'b00, 2'b10, 2'b01, 2'b11};
    logic [3:0]  bp_sh   [6] = '{4'd3, 4'd4, 4'd4, 4'd4, 4'd15, 4'd15};
    logic [15:0] bp_din  [6] = '{16'h0001, 16'h8000, 16'hF00F, 16'h00FF, 16'hFFFF, 16'hFFFF};
    logic [15:0] bp_exp  [6] = '{16'h0008, 16'h0800, 16'h00FF, 16'hF00F, 16'h8000, 16'h0001};

    function automatic logic [15:0] model(input logic [15:0] d, input logic [1:0] op,
                                          input logic [3:0] n);
        logic [15:0] r;
        case (op)
            2'b00:   r = (d << n) | (d >> (16 - int'(n)));
            2'b01:   r = d << n;
            2'b10:   r = (d >> n) | (d << (16 - int'(n)));
            default: r = d >> n;
        endcase
        return r;
    endfunction

    task automatic present(input logic [1:0] op, input logic [3:0] sh, input logic [15:0] d,
                           input logic [3:0] tag);
        in_valid = 1'b1;
        in_op    = op;
        in_shamt = sh;
        in_data  = d;
        in_tag   = tag;
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++; $display("FAIL reset_out_valid got=%b want=0", out_valid);
        end
        checks++;
        if (out_data !== 16'h0) begin
            failures++; $display("FAIL reset_out_data got=%h want=0000", out_data);
        end
        checks++;
        if (out_tag !== 4'h0) begin
            failures++; $display("FAIL reset_out_tag got=%h want=0", out_tag);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++; $display("FAIL reset_in_ready got=%b want=1", in_ready);
        end
    endtask

    task automatic test_sll_latency();
        int cnt;
        @(negedge clk);
        out_ready = 1'b1;
        present(2'b01, 4'd4, 16'h00F1, 4'h5);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++; $display("FAIL sll_in_ready got=%b want=1", in_ready);
        end
        cnt = 0;
        do begin
            @(negedge clk);
            in_valid = 1'b0;
            cnt++;
        end while (!out_valid && cnt < 20);
        checks++;
        if (cnt !== 4) begin
            failures++; $display("FAIL sll_latency got=%0d want=4", cnt);
        end
        checks++;
        if (out_data !== 16'h0F10 || out_tag !== 4'h5) begin
            failures++;
            $display("FAIL sll_result got=%h/%h want=0f10/5", out_data, out_tag);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            failures++; $display("FAIL sll_drained got=%b want=0", out_valid);
        end
    endtask

    task automatic test_back_to_back();
        for (int j = 0; j < 13; j++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== (j >= 4 && j < 12)) begin
                failures++;
                $display("FAIL b2b_valid cycle=%0d got=%b want=%b", j, out_valid,
                         (j >= 4 && j < 12));
            end
            if (j >= 4 && j < 12) begin
                checks++;
                if (out_data !== bb_exp[j-4] || out_tag !== 4'(j - 4)) begin
                    failures++;
                    $display("FAIL b2b_data idx=%0d got=%h/%h want=%h/%h", j - 4, out_data,
                             out_tag, bb_exp[j-4], 4'(j - 4));
                end
            end
            if (j < 8) present(bb_op[j], bb_sh[j], bb_din[j], 4'(j));
            else in_valid = 1'b0;
        end
    endtask

    task automatic test_backpressure();
        int idx = 0;
        @(negedge clk);
        out_ready = 1'b0;
        for (int j = 0; j < 7; j++) begin
            if (j > 0) @(negedge clk);
            if (j >= 4) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== bp_exp[0] || out_tag !== 4'h0) begin
                    failures++;
                    $display("FAIL bp_hold cycle=%0d got=%b/%h/%h want=1/%h/0", j, out_valid,
                             out_data, out_tag, bp_exp[0]);
                end
            end
            present(bp_op[idx], bp_sh[idx], bp_din[idx], 4'(idx));
            #1;
            checks++;
            if (in_ready !== (j < 4)) begin
                failures++;
                $display("FAIL bp_in_ready cycle=%0d got=%b want=%b", j, in_ready, (j < 4));
            end
            if (in_ready) idx++;
        end
        checks++;
        if (idx !== 4) begin
            failures++; $display("FAIL bp_accepted got=%0d want=4", idx);
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++; $display("FAIL bp_ready_return got=%b want=1", in_ready);
        end
        for (int d = 0; d < 7; d++) begin
            if (d > 0) @(negedge clk);
            checks++;
            if (d < 6) begin
                if (out_valid !== 1'b1 || out_data !== bp_exp[d] || out_tag !== 4'(d)) begin
                    failures++;
                    $display("FAIL bp_drain idx=%0d got=%b/%h/%h want=1/%h/%h", d, out_valid,
                             out_data, out_tag, bp_exp[d], 4'(d));
                end
            end else if (out_valid !== 1'b0) begin
                failures++; $display("FAIL bp_empty got=%b want=0", out_valid);
            end
            if (d == 0) present(bp_op[4], bp_sh[4], bp_din[4], 4'h4);
            else if (d == 1) present(bp_op[5], bp_sh[5], bp_din[5], 4'h5);
            else in_valid = 1'b0;
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b1;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            present(2'b01, 4'd1, 16'h0101, 4'(j + 8));
        end
        @(negedge clk);
        flush = 1'b1;
        present(2'b00, 4'd2, 16'h1111, 4'hF);
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            failures++; $display("FAIL flush_in_ready got=%b want=0", in_ready);
        end
        @(negedge clk);
        flush    = 1'b0;
        in_valid = 1'b0;
        for (int j = 0; j < 5; j++) begin
            if (j > 0) @(negedge clk);
            checks++;
            if (out_valid !== 1'b0) begin
                failures++;
                $display("FAIL flush_no_output cycle=%0d got=%b want=0", j, out_valid);
            end
        end
    endtask

    task automatic test_async_reset();
        int cnt;
        out_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            present(2'b10, 4'd3, 16'hAAAA, 4'(j + 1));
        end
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1) begin
            failures++; $display("FAIL arst_pre_valid got=%b want=1", out_valid);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 16'h0 || out_tag !== 4'h0) begin
            failures++;
            $display("FAIL arst_clear got=%b/%h/%h want=0/0000/0", out_valid, out_data, out_tag);
        end
        @(negedge clk);
        rst_n = 1'b1;
        present(2'b00, 4'd8, 16'h0F00, 4'h9);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++; $display("FAIL arst_in_ready got=%b want=1", in_ready);
        end
        cnt = 0;
        do begin
            @(negedge clk);
            in_valid = 1'b0;
            cnt++;
        end while (!out_valid && cnt < 20);
        checks++;
        if (cnt !== 4 || out_data !== 16'h000F || out_tag !== 4'h9) begin
            failures++;
            $display("FAIL arst_first_op got=%0d/%h/%h want=4/000f/9", cnt, out_data, out_tag);
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [15:0] q_data[$];
        logic [3:0]  q_tag[$];
        logic [15:0] held_data = '0;
        logic [3:0]  held_tag = '0;
        logic        hold = 1'b0;
        logic        pending = 1'b0;
        int          sent = 0;
        int          rcvd = 0;
        int          cyc = 0;
        int          n = 300;
        while (rcvd < n && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            if (hold) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== held_data || out_tag !== held_tag) begin
                    failures++;
                    $display("FAIL rnd_stable got=%b/%h/%h want=1/%h/%h", out_valid, out_data,
                             out_tag, held_data, held_tag);
                end
            end
            if (!pending && sent < n && $urandom_range(3) != 0) begin
                in_op    = 2'($urandom_range(3));
                in_shamt = 4'($urandom_range(15));
                in_data  = 16'($urandom);
                in_tag   = 4'($urandom_range(15));
                pending  = 1'b1;
            end
            in_valid  = pending;
            out_ready = ($urandom_range(2) != 0);
            #1;
            if (out_valid && out_ready) begin
                checks++;
                if (q_data.size() == 0) begin
                    failures++; $display("FAIL rnd_extra got=%h/%h want=none", out_data, out_tag);
                end else begin
                    if (out_data !== q_data[0] || out_tag !== q_tag[0]) begin
                        failures++;
                        $display("FAIL rnd_data idx=%0d got=%h/%h want=%h/%h", rcvd, out_data,
                                 out_tag, q_data[0], q_tag[0]);
                    end
                    void'(q_data.pop_front());
                    void'(q_tag.pop_front());
                end
                rcvd++;
            end
            hold      = out_valid && !out_ready;
            held_data = out_data;
            held_tag  = out_tag;
            if (pending && in_ready) begin
                q_data.push_back(model(in_data, in_op, in_shamt));
                q_tag.push_back(in_tag);
                sent++;
                pending = 1'b0;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        checks++;
        if (rcvd !== n) begin
            failures++; $display("FAIL rnd_count got=%0d want=%0d", rcvd, n);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_shamt  = '0;
        in_op     = '0;
        in_tag    = '0;
        out_ready = 1'b1;
        test_reset();
        test_sll_latency();
        test_back_to_back();
        test_backpressure();
        test_flush();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
